// File: rtl/memory_arbiter.sv
// memory_arbiter: round-robin arbiter sharing one RAM port among NREQ cache
// requesters (even index = icache, odd index = dcache). One transaction is
// in flight at a time; each access walks IDLE -> BUSY -> DONE.
// Optional macro DATA_PRIORITY_EN: odd (dcache) requesters win over even
// ones whenever any odd requester is pending.
module memory_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned AW   = 32,
  parameter int unsigned DW   = 32
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NREQ-1:0]    req_ren,
  input  logic [NREQ-1:0]    req_wen,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_store,
  output logic [NREQ-1:0]    req_done,
  output logic [DW-1:0]      req_load,
  output logic [NREQ-1:0]    grant,
  output logic               ram_ren,
  output logic               ram_wen,
  output logic [AW-1:0]      ram_addr,
  output logic [DW-1:0]      ram_store,
  input  logic [DW-1:0]      ram_load,
  input  logic               ram_ready
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IW-1:0]   last_q, last_d;
  logic [NREQ-1:0] req_done_q, req_done_d;
  logic [DW-1:0]   req_load_q, req_load_d;

  logic [NREQ-1:0] pending;
  logic [NREQ-1:0] eligible;
  logic [IW-1:0]   cand;
  logic [IW-1:0]   win_idx;
  logic            win_found;
`ifdef DATA_PRIORITY_EN
  logic [NREQ-1:0] odd_mask;
`endif

  // Round-robin search for the next owner, starting just after last_q.
  always_comb begin
    pending   = req_ren | req_wen;
`ifdef DATA_PRIORITY_EN
    odd_mask  = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      odd_mask[i] = ((i % 2) == 1);
    end
    eligible  = (|(pending & odd_mask)) ? (pending & odd_mask) : pending;
`else
    eligible  = pending;
`endif
    cand      = '0;
    win_idx   = '0;
    win_found = 1'b0;
    for (int k = 1; k <= int'(NREQ); k++) begin
      cand = IW'((32'(last_q) + 32'(k)) % NREQ);
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next-state, RAM-side strobes/muxes and requester-side outputs.
  always_comb begin
    int unsigned sel;
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    req_done_d = '0;
    req_load_d = req_load_q;
    ram_ren    = 1'b0;
    ram_wen    = 1'b0;
    ram_addr   = '0;
    ram_store  = '0;
    sel        = 32'(last_q);

    case (state_q)
      IDLE: begin
        grant_d = '0;
        if (win_found) begin
          grant_d[win_idx] = 1'b1;
          last_d           = win_idx;
          state_d          = BUSY;
        end
      end
      BUSY: begin
        // Live strobes from the owner; a write wins over a simultaneous read.
        ram_wen   = req_wen[last_q];
        ram_ren   = req_ren[last_q] & ~req_wen[last_q];
        ram_addr  = req_addr[sel*AW +: AW];
        ram_store = req_store[sel*DW +: DW];
        if (ram_ready) begin
          if (ram_ren) begin
            req_load_d = ram_load;
          end
          req_done_d = grant_q;
          state_d    = DONE;
        end
      end
      DONE: begin
        grant_d = '0;
        state_d = IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset clears everything without a clock.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      last_q     <= IW'(NREQ - 1);
      req_done_q <= '0;
      req_load_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      req_done_q <= req_done_d;
      req_load_q <= req_load_d;
    end
  end

  assign grant    = grant_q;
  assign req_done = req_done_q;
  assign req_load = req_load_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: tests push expected RAM accesses and
// completions; independent monitors pop and compare when the DUT shows them.
module tb_memory_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;

  logic               CLK = 1'b0;
  logic               RST = 1'b0;
  logic [NREQ-1:0]    req_ren = '0;
  logic [NREQ-1:0]    req_wen = '0;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ*DW-1:0] req_store = '0;
  logic [NREQ-1:0]    req_done;
  logic [DW-1:0]      req_load;
  logic [NREQ-1:0]    grant;
  logic               ram_ren;
  logic               ram_wen;
  logic [AW-1:0]      ram_addr;
  logic [DW-1:0]      ram_store;
  logic [DW-1:0]      ram_load = '0;
  logic               ram_ready = 1'b0;

  typedef struct packed {
    logic [3:0]  grant;
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] store;
  } ram_exp_t;

  typedef struct packed {
    logic [3:0]  done;
    logic [31:0] load;
  } done_exp_t;

  ram_exp_t    ram_q[$];
  done_exp_t   done_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          ram_lat  = 0;
  logic [31:0] ram_data = '0;
  logic [31:0] exp_load = '0;

  memory_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .req_ren   (req_ren),
    .req_wen   (req_wen),
    .req_addr  (req_addr),
    .req_store (req_store),
    .req_done  (req_done),
    .req_load  (req_load),
    .grant     (grant),
    .ram_ren   (ram_ren),
    .ram_wen   (ram_wen),
    .ram_addr  (ram_addr),
    .ram_store (ram_store),
    .ram_load  (ram_load),
    .ram_ready (ram_ready)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Expected access by requester i; reads set the model of req_load.
  task automatic expect_txn(input int i, input logic wr, input logic [31:0] addr,
                            input logic [31:0] store, input logic [31:0] load);
    ram_exp_t  r;
    done_exp_t d;
    r.grant = 4'(1) << i;
    r.ren   = ~wr;
    r.wen   = wr;
    r.addr  = addr;
    r.store = store;
    ram_q.push_back(r);
    if (!wr) exp_load = load;
    d.done = 4'(1) << i;
    d.load = exp_load;
    done_q.push_back(d);
  endtask

  task automatic set_req(input int i, input logic ren, input logic wen,
                         input logic [31:0] addr, input logic [31:0] store);
    req_ren[i] = ren;
    req_wen[i] = wen;
    req_addr[i*AW +: AW]  = addr;
    req_store[i*DW +: DW] = store;
  endtask

  // Advance to the next falling edge; requesters drop their request on done.
  task automatic cycle();
    @(negedge CLK);
    for (int i = 0; i < int'(NREQ); i++) begin
      if (req_done[i]) begin
        req_ren[i] = 1'b0;
        req_wen[i] = 1'b0;
      end
    end
  endtask

  task automatic drain(input int budget);
    int c = 0;
    while ((ram_q.size() != 0 || done_q.size() != 0) && c < budget) begin
      cycle();
      c++;
    end
    check("drain_outstanding", 64'(ram_q.size() + done_q.size()), 64'd0);
    repeat (2) cycle();
  endtask

  // RAM model: raises ram_ready ram_lat cycles after a strobe appears.
  initial begin
    int cnt = 0;
    forever begin
      @(negedge CLK);
      if ((ram_ren || ram_wen) && !ram_ready) begin
        if (cnt >= ram_lat) begin
          ram_ready = 1'b1;
          ram_load  = ram_data ^ ram_addr;
        end else begin
          cnt++;
        end
      end else begin
        ram_ready = 1'b0;
        cnt       = 0;
      end
    end
  end

  // RAM-side monitor: compares each new access against the scoreboard.
  initial begin
    logic     prev = 1'b0;
    ram_exp_t e;
    forever begin
      @(negedge CLK);
      if ((ram_ren || ram_wen) && !prev) begin
        if (ram_q.size() == 0) begin
          n_checks++;
          $display("FAIL ram_unexpected: access to 0x%0h with nothing expected", ram_addr);
        end else begin
          e = ram_q.pop_front();
          check("ram_grant", 64'(grant), 64'(e.grant));
          check("ram_ren",   64'(ram_ren), 64'(e.ren));
          check("ram_wen",   64'(ram_wen), 64'(e.wen));
          check("ram_addr",  64'(ram_addr), 64'(e.addr));
          check("ram_store", 64'(ram_store), 64'(e.store));
        end
      end
      prev = ram_ren | ram_wen;
    end
  end

  // Completion monitor: compares each done pulse and the returned data.
  initial begin
    done_exp_t e;
    forever begin
      @(negedge CLK);
      if (req_done != '0) begin
        if (done_q.size() == 0) begin
          n_checks++;
          $display("FAIL done_unexpected: req_done=0x%0h with nothing expected", req_done);
        end else begin
          e = done_q.pop_front();
          check("req_done", 64'(req_done), 64'(e.done));
          check("req_load", 64'(req_load), 64'(e.load));
        end
      end
    end
  end

  initial begin
    int n, first_c, last_c;
    logic rr, raised;

    // Reset with all four requesters pending.
    #1 RST = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b0, 32'h1000 + 32'(4*i), 32'h5000_0000 + 32'(i));
    ram_lat  = 0;
    ram_data = 32'h1111_0000;
    #11;
    check("rst_grant",     64'(grant), 64'd0);
    check("rst_req_done",  64'(req_done), 64'd0);
    check("rst_req_load",  64'(req_load), 64'd0);
    check("rst_ram_ren",   64'(ram_ren), 64'd0);
    check("rst_ram_wen",   64'(ram_wen), 64'd0);
    check("rst_ram_addr",  64'(ram_addr), 64'd0);
    check("rst_ram_store", 64'(ram_store), 64'd0);
`ifdef DATA_PRIORITY_EN
    expect_txn(1, 1'b0, 32'h1004, 32'h5000_0001, 32'h1111_1004);
    expect_txn(3, 1'b0, 32'h100C, 32'h5000_0003, 32'h1111_100C);
    expect_txn(0, 1'b0, 32'h1000, 32'h5000_0000, 32'h1111_1000);
    expect_txn(2, 1'b0, 32'h1008, 32'h5000_0002, 32'h1111_1008);
`else
    expect_txn(0, 1'b0, 32'h1000, 32'h5000_0000, 32'h1111_1000);
    expect_txn(1, 1'b0, 32'h1004, 32'h5000_0001, 32'h1111_1004);
    expect_txn(2, 1'b0, 32'h1008, 32'h5000_0002, 32'h1111_1008);
    expect_txn(3, 1'b0, 32'h100C, 32'h5000_0003, 32'h1111_100C);
`endif
    @(negedge CLK);
    RST = 1'b0;
    drain(80);

    // All four held; requester 0 re-raises once after its first completion.
    ram_lat  = 0;
    ram_data = 32'h0;
`ifdef DATA_PRIORITY_EN
    expect_txn(3, 1'b0, 32'h200C, 32'h6000_0003, 32'h200C);
    expect_txn(1, 1'b0, 32'h2004, 32'h6000_0001, 32'h2004);
    expect_txn(2, 1'b0, 32'h2008, 32'h6000_0002, 32'h2008);
    expect_txn(0, 1'b0, 32'h2000, 32'h6000_0000, 32'h2000);
    expect_txn(0, 1'b0, 32'h2000, 32'h6000_0000, 32'h2000);
`else
    expect_txn(0, 1'b0, 32'h2000, 32'h6000_0000, 32'h2000);
    expect_txn(1, 1'b0, 32'h2004, 32'h6000_0001, 32'h2004);
    expect_txn(2, 1'b0, 32'h2008, 32'h6000_0002, 32'h2008);
    expect_txn(3, 1'b0, 32'h200C, 32'h6000_0003, 32'h200C);
    expect_txn(0, 1'b0, 32'h2000, 32'h6000_0000, 32'h2000);
`endif
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b0, 32'h2000 + 32'(4*i), 32'h6000_0000 + 32'(i));
    n = 0; first_c = 0; last_c = 0; rr = 1'b0; raised = 1'b0;
    for (int c = 0; c < 100 && n < 5; c++) begin
      cycle();
      if (rr) begin
        req_ren[0] = 1'b1;
        rr = 1'b0;
      end
      if (req_done != '0) begin
        if (n == 0) first_c = c;
        last_c = c;
        n++;
        if (req_done[0] && !raised) begin
          rr     = 1'b1;
          raised = 1'b1;
        end
      end
    end
    check("rr_count",   64'(n), 64'd5);
    check("rr_spacing", 64'(last_c - first_c), 64'd12);
    drain(40);

    // Single read, ram_ready three cycles after the strobe rises.
    ram_lat  = 3;
    ram_data = 32'hDEADBFEF;  // XOR with address 0x100 returns 0xDEADBEEF
    expect_txn(2, 1'b0, 32'h100, 32'hCAFE_0002, 32'hDEAD_BEEF);
    set_req(2, 1'b1, 1'b0, 32'h100, 32'hCAFE_0002);
    cycle();
    check("rd_ram_ren",  64'(ram_ren), 64'd1);
    check("rd_ram_addr", 64'(ram_addr), 64'h100);
    repeat (4) begin
      check("rd_no_early_done", 64'(req_done), 64'd0);
      cycle();
    end
    check("rd_done_latency", 64'(req_done), 64'b0100);
    drain(40);

    // Single write, ram_ready immediate; req_load must keep the read data.
    ram_lat = 0;
    expect_txn(1, 1'b1, 32'h200, 32'h1234_5678, 32'h0);
    set_req(1, 1'b0, 1'b1, 32'h200, 32'h1234_5678);
    cycle();
    check("wr_ram_wen", 64'(ram_wen), 64'd1);
    check("wr_ram_ren", 64'(ram_ren), 64'd0);
    drain(40);
    check("wr_load_held", 64'(req_load), 64'hDEAD_BEEF);

    // Reset during BUSY: strobes fall at once, no done, restart from index 0.
    ram_lat = 20;
    begin
      ram_exp_t r;
      r.grant = 4'b0100; r.ren = 1'b1; r.wen = 1'b0; r.addr = 32'h300; r.store = 32'h7000_0002;
      ram_q.push_back(r);
    end
    set_req(2, 1'b1, 1'b0, 32'h300, 32'h7000_0002);
    cycle();
    set_req(3, 1'b1, 1'b0, 32'h304, 32'h7000_0003);
    #2 RST = 1'b1;
    #1;
    check("mid_rst_ram_ren",  64'(ram_ren), 64'd0);
    check("mid_rst_grant",    64'(grant), 64'd0);
    check("mid_rst_req_done", 64'(req_done), 64'd0);
    ram_lat  = 1;
    ram_data = 32'h0000_7700;
    exp_load = 32'h0;
`ifdef DATA_PRIORITY_EN
    expect_txn(3, 1'b0, 32'h304, 32'h7000_0003, 32'h7404);
    expect_txn(2, 1'b0, 32'h300, 32'h7000_0002, 32'h7400);
`else
    expect_txn(2, 1'b0, 32'h300, 32'h7000_0002, 32'h7400);
    expect_txn(3, 1'b0, 32'h304, 32'h7000_0003, 32'h7404);
`endif
    cycle();
    RST = 1'b0;
    drain(60);

    // Requesters 0 and 1 both pending out of reset.
    RST      = 1'b1;
    ram_lat  = 0;
    ram_data = 32'h0;
    set_req(0, 1'b1, 1'b0, 32'h400, 32'h8000_0000);
    set_req(1, 1'b1, 1'b0, 32'h404, 32'h8000_0001);
`ifdef DATA_PRIORITY_EN
    expect_txn(1, 1'b0, 32'h404, 32'h8000_0001, 32'h404);
    expect_txn(0, 1'b0, 32'h400, 32'h8000_0000, 32'h400);
`else
    expect_txn(0, 1'b0, 32'h400, 32'h8000_0000, 32'h400);
    expect_txn(1, 1'b0, 32'h404, 32'h8000_0001, 32'h404);
`endif
    cycle();
    RST = 1'b0;
    drain(40);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
